i2c_reg_bank: RTL and testbench
===============================

# i2c_reg_bank

Clock-domain register bank sitting directly downstream of the SCL-clocked I2C peripheral. It resynchronises the peripheral's byte-complete and transaction-active signals into the system clock, and interprets the first written byte of each transaction as a register pointer and later bytes as register data. It supplies the next transmit byte back to the peripheral for reads and exposes the whole register file, plus a local write port, to the rest of the FPGA.

## Interface
- `DEPTH`, 16: number of 8-bit registers; power of two, 2..256. `AW = $clog2(DEPTH)`.
- `RESET_VAL`, 8'h00: reset value of every register.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset is synchronous and active-low.
- `rx_byte`  in  8: last received byte from the peripheral; asynchronous, stable while `byte_evt_a` is high.
- `rw`  in  1: peripheral direction flag; 1 = controller read. Asynchronous, stable during a transaction.
- `byte_evt_a`  in  1: asynchronous pulse, one per completed data byte (write byte received or read byte acked).
- `xfer_active_a`  in  1: asynchronous level, high from the address-ACK to the STOP/NACK.
- `tx_byte`  out  8: byte for the peripheral to shift out on the next read; registered.
- `lcl_we`  in  1: local write enable.
- `lcl_addr`  in  AW: local write address.
- `lcl_data`  in  8: local write data.
- `regs_out`  out  DEPTH*8: flat register file; register k is at bits [8k+7:8k].
- `wr_pulse`  out  1: one-cycle strobe on every I2C-originated register write.
- `wr_addr`  out  AW: address of the last I2C write; valid while `wr_pulse` is high.

## Operation
- **Synchronisers.** Each of `byte_evt_a`, `xfer_active_a` and `rw` passes through a 2-flop synchroniser, all flops reset to 0.
- **Edge detect.** A third flop on each synced line gives edge detection:
  - `evt` = synced `byte_evt_a` rising.
  - `start` = synced active rising.
  - `end` = synced active falling.
- **Data capture.** `rx_byte` is sampled unsynchronised in the cycle `evt` is high. Legality comes from the stability requirement in Timing.
- **Arming.** An `armed` flag resets to 0 and sets once synced active is seen low. `start` is ignored while unarmed, so a reset mid-transaction discards that transaction's remaining bytes.
- **State machine: IDLE, PTR, WDATA, RDATA.**
  - IDLE: on `start` & armed, go to PTR if synced rw = 0, else to RDATA. `evt` in IDLE is ignored.
  - PTR: on `evt`, `ptr <= rx_byte[AW-1:0]` (upper bits dropped), then go to WDATA.
  - WDATA: on `evt`, `reg[ptr] <= rx_byte`, `wr_pulse <= 1`, `wr_addr <= ptr`, `ptr <= ptr+1` (wraps DEPTH-1 -> 0).
  - RDATA: on `evt`, `ptr <= ptr+1` with the same wrap.
  - `end` in any state returns to IDLE. `ptr` is retained, so write-pointer / repeated-start / read works.
- **tx_byte.** `tx_byte <= reg[ptr]` every cycle; it reflects pointer and register updates one cycle later.
- **Local write.** `lcl_we` writes `reg[lcl_addr] <= lcl_data` in any state. If it lands in the same cycle as an I2C write to the same address, the I2C write wins and the local write is dropped. Different addresses both commit.
- **Reset values.** All registers = RESET_VAL, `ptr` = 0, `tx_byte` = RESET_VAL, `wr_pulse` = 0, `wr_addr` = 0, state = IDLE, `armed` = 0.

## Timing
- **Input pulse widths.** `byte_evt_a` must be high >= 3 clk periods and low >= 3 clk periods. `xfer_active_a` must be low >= 3 clk between transactions.
- **Input stability.** `rx_byte` must be stable from before `byte_evt_a` rises until 4 clk after. `rw` must be stable before `xfer_active_a` rises.
- **Latency.** With `byte_evt_a` rising just before clk edge 0:
  - `evt` is high in cycle 3.
  - Register / `ptr` updates are visible and `wr_pulse` is high in cycle 4.
  - `tx_byte` is updated in cycle 5.
- **Local write.** Visible on `regs_out` 1 cycle after `lcl_we`.
- **Coincident edges.** `start` and `evt` in the same cycle: the state transition is taken and `evt` is ignored. `end` and `evt` in the same cycle: `evt` is processed, then the state goes to IDLE.
- **Read timing.** The peripheral loads `tx_byte` at the start of each read byte. `tx_byte` must be settled within 5 clk of the previous byte's event, which bounds clk >= ~12x SCL.

## Test plan
- **Write burst.** Reset, then transaction rw=0 with bytes 0x02, 0xAA, 0xBB -> reg2 = 0xAA, reg3 = 0xBB, two `wr_pulse` with `wr_addr` 2 then 3, final ptr = 4.
- **Wrap and pointer masking.** Write with pointer 0x1F (DEPTH=16) and data 0x11, 0x22 -> reg15 = 0x11, reg0 = 0x22; upper pointer bits ignored.
- **Pointer then read.** Write pointer 0x05 then end; preload reg5 = 0x5A and reg6 = 0xC3 via the local port; read transaction -> `tx_byte` = 0x5A, then 0xC3 five cycles after the first `byte_evt_a` rise.
- **Collision.** `lcl_we` to addr 3 with 0x77 in the same cycle as an I2C write 0x99 to addr 3 -> reg3 = 0x99. Repeat with `lcl_addr` = 4 -> reg3 = 0x99 and reg4 = 0x77.
- **Reset mid-transaction.** Assert `rst_n` low for 1 cycle after the pointer byte while `xfer_active_a` stays high, then send data 0x44 -> no register changes, no `wr_pulse`; the next full transaction works normally.
- **Minimum pulse width.** `byte_evt_a` held exactly 3 clk with `rx_byte` changing 5 clk after the rise -> the correct byte is captured and exactly one event occurs.

Source files
------------

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: system-clock register bank behind an SCL-clocked I2C peripheral.
// The first write byte loads the pointer, later bytes write registers; tx_byte follows reg[ptr].
module i2c_reg_bank #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] RESET_VAL = 8'h00,
  localparam int        AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_byte,
  input  logic               rw,
  input  logic               byte_evt_a,
  input  logic               xfer_active_a,
  output logic [7:0]         tx_byte,
  input  logic               lcl_we,
  input  logic [AW-1:0]      lcl_addr,
  input  logic [7:0]         lcl_data,
  output logic [DEPTH*8-1:0] regs_out,
  output logic               wr_pulse,
  output logic [AW-1:0]      wr_addr
);

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    WDATA,
    RDATA
  } state_t;

  logic [2:0]    ev_s;
  logic [2:0]    ac_s;
  logic [1:0]    rw_s;
  logic [1:0]    vld;
  logic          armed;
  logic          evt;
  logic          start;
  logic          stop;

  state_t        state;
  state_t        state_d;
  logic [AW-1:0] ptr;
  logic          ptr_ld;
  logic          ptr_inc;
  logic          i2c_we;
  logic [7:0]    regs [DEPTH];

  // vld keeps armed off until the synchronisers hold real samples,
  // so the reset-zeroed pipeline is not mistaken for an idle bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_s  <= '0;
      ac_s  <= '0;
      rw_s  <= '0;
      vld   <= '0;
      armed <= 1'b0;
      evt   <= 1'b0;
      start <= 1'b0;
      stop  <= 1'b0;
    end else begin
      ev_s  <= {ev_s[1:0], byte_evt_a};
      ac_s  <= {ac_s[1:0], xfer_active_a};
      rw_s  <= {rw_s[0], rw};
      vld   <= {vld[0], 1'b1};
      if (vld[1] && !ac_s[1])
        armed <= 1'b1;
      evt   <= ev_s[1] & ~ev_s[2];
      start <= ac_s[1] & ~ac_s[2];
      stop  <= ~ac_s[1] & ac_s[2];
    end
  end

  always_comb begin
    state_d = state;
    ptr_ld  = 1'b0;
    ptr_inc = 1'b0;
    i2c_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && armed)
          state_d = rw_s[1] ? RDATA : PTR;
      end
      PTR: begin
        if (evt) begin
          ptr_ld  = 1'b1;
          state_d = WDATA;
        end
      end
      WDATA: begin
        if (evt) begin
          i2c_we  = 1'b1;
          ptr_inc = 1'b1;
        end
      end
      RDATA: begin
        if (evt)
          ptr_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (stop)
      state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tx_byte  <= RESET_VAL;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      for (int k = 0; k < DEPTH; k++)
        regs[k] <= RESET_VAL;
    end else begin
      state    <= state_d;
      wr_pulse <= i2c_we;
      tx_byte  <= regs[ptr];
      if (i2c_we)
        wr_addr <= ptr;
      if (ptr_ld)
        ptr <= rx_byte[AW-1:0];
      else if (ptr_inc)
        ptr <= ptr + 1'b1;
      // I2C write takes priority over a local write to the same register
      for (int k = 0; k < DEPTH; k++) begin
        if (i2c_we && ptr == AW'(k))
          regs[k] <= rx_byte;
        else if (lcl_we && lcl_addr == AW'(k))
          regs[k] <= lcl_data;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int k = 0; k < DEPTH; k++)
      regs_out[8*k +: 8] = regs[k];
  end

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank: randomized scoreboard bench for i2c_reg_bank.
// A byte-level model predicts writes, pointer movement and tx_byte.
module tb_i2c_reg_bank;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         rx_byte = '0;
  logic               rw = 1'b0;
  logic               byte_evt_a = 1'b0;
  logic               xfer_active_a = 1'b0;
  logic [7:0]         tx_byte;
  logic               lcl_we = 1'b0;
  logic [AW-1:0]      lcl_addr = '0;
  logic [7:0]         lcl_data = '0;
  logic [DEPTH*8-1:0] regs_out;
  logic               wr_pulse;
  logic [AW-1:0]      wr_addr;

  i2c_reg_bank #(.DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_byte(rx_byte),
    .rw(rw),
    .byte_evt_a(byte_evt_a),
    .xfer_active_a(xfer_active_a),
    .tx_byte(tx_byte),
    .lcl_we(lcl_we),
    .lcl_addr(lcl_addr),
    .lcl_data(lcl_data),
    .regs_out(regs_out),
    .wr_pulse(wr_pulse),
    .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] mptr;
  bit            m_live;
  bit            m_read;
  bit            m_got_ptr;
  bit            m_armed;
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int reg_at(int a);
    return int'(regs_out[8*a +: 8]);
  endfunction

  always @(negedge clk) begin
    if (rst_n && wr_pulse) begin
      chk("wr_pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), int'(mon_e.a));
        chk("wr_data", reg_at(int'(mon_e.a)), int'(mon_e.d));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++)
      mem[k] = 8'h00;
    mptr    = '0;
    m_live  = 1'b0;
    m_armed = !xfer_active_a;
  endtask

  task automatic start_xfer(input bit r);
    rw = r;
    @(negedge clk);
    xfer_active_a = 1'b1;
    repeat (4) @(negedge clk);
    m_live    = m_armed;
    m_read    = r;
    m_got_ptr = 1'b0;
  endtask

  task automatic end_xfer();
    xfer_active_a = 1'b0;
    repeat (5) @(negedge clk);
    m_live  = 1'b0;
    m_armed = 1'b1;
    chk("tx_after_xfer", int'(tx_byte), int'(mem[mptr]));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit col,
                           input logic [AW-1:0] ca, input logic [7:0] cd);
    bit            wr;
    logic [AW-1:0] wa;
    wr_t           e;
    wr = m_live && !m_read && m_got_ptr;
    wa = mptr;
    rx_byte    = b;
    byte_evt_a = 1'b1;
    if (m_live && !m_read && !m_got_ptr) begin
      mptr      = b[AW-1:0];
      m_got_ptr = 1'b1;
    end else if (wr) begin
      e.a = wa;
      e.d = b;
      exp_q.push_back(e);
      mptr = mptr + 1'b1;
    end else if (m_live && m_read) begin
      mptr = mptr + 1'b1;
    end
    if (col)
      mem[ca] = cd;
    if (wr)
      mem[wa] = b;
    repeat (3) @(negedge clk);
    byte_evt_a = 1'b0;
    if (col) begin
      lcl_we   = 1'b1;
      lcl_addr = ca;
      lcl_data = cd;
    end
    @(negedge clk);
    lcl_we = 1'b0;
    @(negedge clk);
    rx_byte = 8'($urandom);
    if (m_live && m_read)
      chk("tx_read", int'(tx_byte), int'(mem[mptr]));
    repeat (2) @(negedge clk);
  endtask

  task automatic lcl_write(input logic [AW-1:0] a, input logic [7:0] d);
    lcl_we   = 1'b1;
    lcl_addr = a;
    lcl_data = d;
    @(negedge clk);
    lcl_we = 1'b0;
    mem[a] = d;
    chk("lcl_write", reg_at(int'(a)), int'(d));
  endtask

  initial begin
    int          n;
    bit          col;
    logic [AW-1:0] ca;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    chk("rst_tx", int'(tx_byte), 0);
    chk("rst_wr_pulse", int'(wr_pulse), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_regs_zero", int'(regs_out == '0), 1);

    start_xfer(1'b0);
    send_byte(8'h02, 1'b0, '0, '0);
    send_byte(8'hAA, 1'b0, '0, '0);
    send_byte(8'hBB, 1'b0, '0, '0);
    end_xfer();
    chk("burst_reg2", reg_at(2), 8'hAA);
    chk("burst_reg3", reg_at(3), 8'hBB);

    start_xfer(1'b0);
    send_byte(8'h1F, 1'b0, '0, '0);
    send_byte(8'h11, 1'b0, '0, '0);
    send_byte(8'h22, 1'b0, '0, '0);
    end_xfer();
    chk("wrap_reg15", reg_at(15), 8'h11);
    chk("wrap_reg0", reg_at(0), 8'h22);

    start_xfer(1'b0);
    send_byte(8'h05, 1'b0, '0, '0);
    end_xfer();
    lcl_write(4'd5, 8'h5A);
    lcl_write(4'd6, 8'hC3);
    @(negedge clk);
    start_xfer(1'b1);
    chk("read_first", int'(tx_byte), 8'h5A);
    send_byte(8'h00, 1'b0, '0, '0);
    end_xfer();

    start_xfer(1'b0);
    send_byte(8'h03, 1'b0, '0, '0);
    send_byte(8'h99, 1'b1, 4'd3, 8'h77);
    end_xfer();
    chk("col_same_reg3", reg_at(3), 8'h99);
    start_xfer(1'b0);
    send_byte(8'h03, 1'b0, '0, '0);
    send_byte(8'h99, 1'b1, 4'd4, 8'h77);
    end_xfer();
    chk("col_diff_reg3", reg_at(3), 8'h99);
    chk("col_diff_reg4", reg_at(4), 8'h77);

    start_xfer(1'b0);
    send_byte(8'h07, 1'b0, '0, '0);
    do_reset();
    send_byte(8'h44, 1'b0, '0, '0);
    chk("midrst_regs_zero", int'(regs_out == '0), 1);
    chk("midrst_tx", int'(tx_byte), 0);
    end_xfer();
    start_xfer(1'b0);
    send_byte(8'h01, 1'b0, '0, '0);
    send_byte(8'h55, 1'b0, '0, '0);
    end_xfer();
    chk("postrst_reg1", reg_at(1), 8'h55);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0: begin
          start_xfer(1'b0);
          send_byte(8'($urandom), 1'b0, '0, '0);
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++) begin
            col = ($urandom_range(0, 2) == 0);
            ca  = $urandom_range(0, 1) ? mptr : AW'($urandom);
            send_byte(8'($urandom), col, ca, 8'($urandom));
          end
          end_xfer();
        end
        1: begin
          start_xfer(1'b1);
          chk("tx_read_first", int'(tx_byte), int'(mem[mptr]));
          n = $urandom_range(1, 4);
          for (int i = 0; i < n; i++)
            send_byte(8'($urandom), 1'b0, '0, '0);
          end_xfer();
        end
        default: begin
          lcl_write(AW'($urandom), 8'($urandom));
          @(negedge clk);
        end
      endcase
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    for (int k = 0; k < DEPTH; k++)
      chk("final_reg", reg_at(k), int'(mem[k]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
